// File: rtl/thor2024_mem_dispatch_pkg.sv
// Shared types for the memory dispatch stage: queue indexing, queue entry view,
// data-cache request payload and outstanding-request tracker states.
package thor2024_mem_dispatch_pkg;

    localparam int QENTRIES = 8;
    localparam int MEM_NTRK = 2;

    typedef logic [$clog2(QENTRIES)-1:0] que_ndx_t;
    typedef logic [QENTRIES-1:0]         que_bitmask_t;
    typedef logic [31:0]                 address_t;
    typedef logic [63:0]                 value_t;
    typedef logic [1:0]                  memsz_t;

    typedef struct packed {
        address_t a1;
        value_t   a2;
        memsz_t   memsz;
        logic     load;
    } iq_entry_t;

    typedef struct packed {
        logic     tag;
        logic     load;
        memsz_t   memsz;
        address_t adr;
        value_t   dat;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, QUEUED, SENT, CANCEL} mem_trk_state_t;

endpackage

// File: rtl/thor2024_mem_tracker.sv
// One outstanding memory request: lifecycle FSM plus the payload latched at capture.
module thor2024_mem_tracker
    import thor2024_mem_dispatch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           capture,
    input  logic           accept,
    input  logic           resp,
    input  que_bitmask_t   iqentry_stomp,
    input  que_ndx_t       cap_ndx,
    input  iq_entry_t      cap_ent,
    output mem_trk_state_t state,
    output que_ndx_t       ndx,
    output logic           load,
    output memsz_t         memsz,
    output address_t       adr,
    output value_t         dat
);

    logic stomp;
    assign stomp = iqentry_stomp[ndx];

    // An accept that coincides with a stomp still goes out; the response is then swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (capture) state <= QUEUED;
                QUEUED:  if (accept) state <= stomp ? CANCEL : SENT;
                         else if (stomp) state <= IDLE;
                SENT:    if (resp) state <= IDLE;
                         else if (stomp) state <= CANCEL;
                CANCEL:  if (resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture && state == IDLE) begin
            ndx   <= cap_ndx;
            load  <= cap_ent.load;
            memsz <= cap_ent.memsz;
            adr   <= cap_ent.a1;
            dat   <= cap_ent.load ? '0 : cap_ent.a2;
        end
    end

endmodule

// File: rtl/thor2024_mem_dispatch.sv
// Memory dispatch: picks the oldest issuable queue entry, hands it to a free tracker,
// arbitrates tracker requests onto the cache channel and returns tagged completions.
module thor2024_mem_dispatch
    import thor2024_mem_dispatch_pkg::que_ndx_t, thor2024_mem_dispatch_pkg::que_bitmask_t,
           thor2024_mem_dispatch_pkg::iq_entry_t, thor2024_mem_dispatch_pkg::mem_req_t,
           thor2024_mem_dispatch_pkg::mem_trk_state_t, thor2024_mem_dispatch_pkg::address_t,
           thor2024_mem_dispatch_pkg::value_t, thor2024_mem_dispatch_pkg::memsz_t,
           thor2024_mem_dispatch_pkg::IDLE, thor2024_mem_dispatch_pkg::QUEUED,
           thor2024_mem_dispatch_pkg::SENT;
#(
    parameter int QENTRIES = 8,
    parameter int NTRK     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  que_ndx_t     head0,
    input  que_ndx_t     head1,
    input  que_ndx_t     head2,
    input  que_ndx_t     head3,
    input  que_ndx_t     head4,
    input  que_ndx_t     head5,
    input  que_ndx_t     head6,
    input  que_ndx_t     head7,
    input  que_bitmask_t iqentry_memissue,
    input  que_bitmask_t iqentry_stomp,
    input  iq_entry_t    iq [QENTRIES],
    output que_bitmask_t issued_o,
    output logic         mem_req_v_o,
    input  logic         mem_req_rdy_i,
    output mem_req_t     mem_req_o,
    input  logic         mem_resp_v_i,
    input  logic         mem_resp_tag_i,
    input  value_t       mem_resp_dat_i,
    input  logic         mem_resp_err_i,
    output logic         done_v_o,
    output que_ndx_t     done_ndx_o,
    output value_t       done_dat_o,
    output logic         done_exc_o,
    output logic         busy_o
);

    que_ndx_t       heads [QENTRIES];
    mem_trk_state_t trk_state [NTRK];
    que_ndx_t       trk_ndx   [NTRK];
    logic           trk_load  [NTRK];
    memsz_t         trk_memsz [NTRK];
    address_t       trk_adr   [NTRK];
    value_t         trk_dat   [NTRK];

    que_bitmask_t held;
    logic         sel_found, free_found, capture_any;
    que_ndx_t     sel_ndx;
    logic         free_trk, req_sel, last_cap, q0, q1, done_hit;

    assign heads = '{head0, head1, head2, head3, head4, head5, head6, head7};

    // Entries already owned by a tracker (including cancelled ones awaiting a response).
    always_comb begin
        held = '0;
        for (int t = 0; t < NTRK; t++)
            if (trk_state[t] != IDLE) held[trk_ndx[t]] = 1'b1;
    end

    always_comb begin
        sel_found = 1'b0;
        sel_ndx   = '0;
        for (int i = 0; i < QENTRIES; i++) begin
            if (!sel_found && iqentry_memissue[heads[i]] && !iqentry_stomp[heads[i]]
                && !held[heads[i]]) begin
                sel_found = 1'b1;
                sel_ndx   = heads[i];
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_trk   = 1'b0;
        for (int t = NTRK - 1; t >= 0; t--) begin
            if (trk_state[t] == IDLE) begin
                free_found = 1'b1;
                free_trk   = 1'(t);
            end
        end
    end

    assign capture_any = sel_found && free_found;

    // With two trackers the older queued one is whichever was not captured last.
    assign q0          = (trk_state[0] == QUEUED);
    assign q1          = (trk_state[1] == QUEUED);
    assign req_sel     = (q0 && q1) ? ~last_cap : q1;
    assign mem_req_v_o = q0 || q1;
    assign busy_o      = (trk_state[0] != IDLE) || (trk_state[1] != IDLE);

    always_comb begin
        mem_req_o = '0;
        if (mem_req_v_o) begin
            mem_req_o.tag   = req_sel;
            mem_req_o.load  = trk_load[req_sel];
            mem_req_o.memsz = trk_memsz[req_sel];
            mem_req_o.adr   = trk_adr[req_sel];
            mem_req_o.dat   = trk_dat[req_sel];
        end
    end

    for (genvar g = 0; g < NTRK; g++) begin : g_trk
        thor2024_mem_tracker u_trk (
            .clk           (clk),
            .rst           (rst),
            .capture       (capture_any && free_trk == 1'(g)),
            .accept        (mem_req_v_o && mem_req_rdy_i && req_sel == 1'(g)),
            .resp          (mem_resp_v_i && mem_resp_tag_i == 1'(g)),
            .iqentry_stomp (iqentry_stomp),
            .cap_ndx       (sel_ndx),
            .cap_ent       (iq[sel_ndx]),
            .state         (trk_state[g]),
            .ndx           (trk_ndx[g]),
            .load          (trk_load[g]),
            .memsz         (trk_memsz[g]),
            .adr           (trk_adr[g]),
            .dat           (trk_dat[g])
        );
    end

    // A response completes only for a SENT tracker whose entry is not being squashed now.
    assign done_hit = mem_resp_v_i && trk_state[mem_resp_tag_i] == SENT
                      && !iqentry_stomp[trk_ndx[mem_resp_tag_i]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_o   <= '0;
            last_cap   <= 1'b0;
            done_v_o   <= 1'b0;
            done_ndx_o <= '0;
            done_dat_o <= '0;
            done_exc_o <= 1'b0;
        end else begin
            issued_o   <= capture_any ? (que_bitmask_t'(1) << sel_ndx) : '0;
            if (capture_any) last_cap <= free_trk;
            done_v_o   <= done_hit;
            done_exc_o <= done_hit && mem_resp_err_i;
            if (done_hit) begin
                done_ndx_o <= trk_ndx[mem_resp_tag_i];
                done_dat_o <= trk_load[mem_resp_tag_i] ? mem_resp_dat_i : '0;
            end
        end
    end

endmodule

// File: doc/thor2024_mem_dispatch.md
# thor2024_mem_dispatch

Memory dispatch stage directly downstream of the memory-issue selector. It takes the per-entry memory-issue bitmask, picks the oldest issuable entry in head order, and captures its address, data and operation into one of two outstanding-request trackers. It drives a valid/ready request channel to the data cache and returns tagged completions, with load data or store acknowledge, to the queue writeback path. Requests whose queue entry is stomped are cancelled or their responses discarded.

## Interface
Parameters:
- QENTRIES, 8, queue depth; must equal package QENTRIES
- NTRK, 2, outstanding-request trackers; tag width = 1 bit

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- head0..head7  in  que_ndx_t each  queue indices, oldest first
- iqentry_memissue  in  que_bitmask_t  entries cleared to issue to memory
- iqentry_stomp  in  que_bitmask_t  entries being squashed this cycle
- iq  in  iq_entry_t[QENTRIES]  queue contents: a1 (address), a2 (store data), memsz, load
- issued_o  out  que_bitmask_t  one-hot pulse: entry captured by a tracker
- mem_req_v_o  out  1  request valid
- mem_req_rdy_i  in  1  cache accepts request
- mem_req_o  out  mem_req_t  {tag, load, memsz, adr[address_t], dat[value_t]}
- mem_resp_v_i  in  1  response valid, always accepted
- mem_resp_tag_i  in  1  response tag
- mem_resp_dat_i  in  value_t  load data
- mem_resp_err_i  in  1  bus/access error
- done_v_o  out  1  completion valid
- done_ndx_o  out  que_ndx_t  completing queue entry
- done_dat_o  out  value_t  load data; 0 for stores
- done_exc_o  out  1  completion carries memory exception
- busy_o  out  1  any tracker not IDLE

## Operation
- Per-tracker FSM: IDLE -> QUEUED on capture; QUEUED -> SENT on mem_req_v_o & mem_req_rdy_i; SENT -> IDLE on matching response; QUEUED -> IDLE on stomp of its entry (request never issued); SENT -> CANCEL on stomp; CANCEL -> IDLE on matching response, no completion.
- Selection: scan head0..head7 in order; first entry with memissue set, stomp clear and no tracker holding it. Capture only if a tracker is IDLE; lowest-numbered IDLE tracker used. At most one capture per cycle.
- Capture latches ndx, load, memsz, a1, a2. a2 forced to 0 for loads.
- Request channel presents the oldest QUEUED tracker (capture order, 1-bit age flag). Payload held stable while mem_req_v_o and not ready.
- Completion: load -> done_dat_o = mem_resp_dat_i; store -> 0; done_exc_o = mem_resp_err_i.
- Response whose tag maps to an IDLE tracker is dropped silently.

## Timing
- Reset: all trackers IDLE; issued_o, mem_req_v_o, done_v_o, done_exc_o, busy_o = 0; mem_req_o, done_ndx_o, done_dat_o = 0.
- memissue sampled at edge N; tracker QUEUED and issued_o pulsed after edge N+1; mem_req_v_o high in that same cycle. Best-case entry-to-request latency is 1 cycle.
- Response at edge R -> done_v_o after edge R+1, one cycle wide.
- Response frees its tracker at edge R; the tracker is reusable for a capture at edge R+1, not at R.
- Stomp coincident with selection: entry not captured. Stomp coincident with the accept handshake: the request is still accepted and the tracker goes to CANCEL.
- Stomp and response coincident on a SENT tracker: response discarded, tracker -> IDLE, no done.
- Both trackers busy: memissue ignored and no issued_o. The selector re-asserts memissue later; this block does not buffer it.
- Reset mid-transaction: all trackers return to IDLE. Late responses are dropped by the IDLE-tag rule.

## Structure
- Thor2024pkg additions: mem_req_t struct, mem_trk_state_t enum {IDLE, QUEUED, SENT, CANCEL}, constant MEM_NTRK = 2.
- Sub-module thor2024_mem_tracker, instantiated NTRK times: holds the FSM and the latched payload, takes capture/accept/stomp/response strobes.
- Top level holds the head-order selector, the request arbiter and the completion register.

## Test plan
- Single load: memissue[head0=3], a1=0x1000, rdy=1 -> issued_o=0x08 and mem_req {tag0, load, adr 0x1000} next cycle. Response dat=0xDEAD at R -> done_v, ndx 3, dat 0xDEAD at R+1.
- Backpressure: rdy=0 for 4 cycles -> mem_req_o stable and valid throughout. Accept on cycle 5; exactly one request observed.
- Three requests issued back-to-back with no responses -> two captured (tags 0, 1) and third ignored with no issued_o. After response tag0, third captured into tracker 0 on the following cycle.
- Stomp in QUEUED with rdy=0 -> no request ever accepted, busy_o=0 after one cycle. Stomp in SENT -> response arrives, no done_v.
- Store with mem_resp_err_i=1 -> done_v, done_dat=0, done_exc=1.
- Reset asserted while tracker SENT, then response tag0 -> no done_v. All outputs 0 during reset.
